// File: rtl/uart_fp_tx.sv
// 8N1 UART transmitter that returns an N_BYTES-wide Fp word to the host, least-significant byte first.
// Define UART_TX_CHECKSUM_EN to append one extra frame carrying the XOR of all data bytes.

package PARAM_UART;
  localparam int unsigned UART_CLK_FREQ  = 100_000_000;
  localparam int unsigned UART_BAUD_RATE = 460_800;
endpackage

module uart_fp_tx #(
  parameter int unsigned CLK_FREQ  = PARAM_UART::UART_CLK_FREQ,
  parameter int unsigned BAUD_RATE = PARAM_UART::UART_BAUD_RATE,
  parameter int unsigned N_BYTES   = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [8*N_BYTES-1:0]   i_data,
  output logic                   o_ready,
  output logic                   o_txd,
  output logic                   o_busy
);

  localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_CHECKSUM_EN
  localparam int unsigned N_FRAMES = N_BYTES + 1;
`else
  localparam int unsigned N_FRAMES = N_BYTES;
`endif
  localparam int unsigned BAUD_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int unsigned BYTE_W = $clog2(N_FRAMES + 1);
  localparam int unsigned SR_W   = 8 * N_FRAMES;

  if (DIV < 2) begin : g_div_check
    $error("uart_fp_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [2:0]        next_bit;
  logic [BYTE_W-1:0] byte_cnt;
  logic [SR_W-1:0]   shreg;
  logic [SR_W-1:0]   load_word;
  logic              accept;
  logic              baud_tick;
  logic              last_frame;
  logic              txd_next;

  assign accept     = i_valid && o_ready;
  assign baud_tick  = (baud_cnt == BAUD_W'(DIV - 1));
  assign last_frame = (byte_cnt == BYTE_W'(N_FRAMES - 1));
  assign next_bit   = bit_cnt + 3'd1;

`ifdef UART_TX_CHECKSUM_EN
  logic [7:0] checksum;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    checksum = '0;
    for (int i = 0; i < N_BYTES; i++) checksum ^= i_data[8*i +: 8];
  end

  assign load_word = {checksum, i_data};
`else
  assign load_word = i_data;
`endif

  // The next line level is decided here so o_txd can come straight from a flop.
  always_comb begin
    state_next = state;
    txd_next   = o_txd;
    case (state)
      IDLE: begin
        txd_next = 1'b1;
        if (accept) begin
          state_next = START;
          txd_next   = 1'b0;
        end
      end
      START: if (baud_tick) begin
        state_next = DATA;
        txd_next   = shreg[0];
      end
      DATA: if (baud_tick) begin
        if (bit_cnt == 3'd7) begin
          state_next = STOP;
          txd_next   = 1'b1;
        end else begin
          txd_next = shreg[next_bit];
        end
      end
      STOP: if (baud_tick) begin
        if (last_frame) begin
          state_next = IDLE;
          txd_next   = 1'b1;
        end else begin
          state_next = START;
          txd_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      o_txd    <= 1'b1;
      o_ready  <= 1'b0;
      o_busy   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      state   <= state_next;
      o_txd   <= txd_next;
      o_ready <= (state_next == IDLE);
      o_busy  <= (state_next != IDLE);
      if (accept) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (state != IDLE) begin
        baud_cnt <= baud_tick ? '0 : baud_cnt + BAUD_W'(1);
        if (baud_tick && state == DATA) bit_cnt  <= bit_cnt + 3'd1;
        if (baud_tick && state == STOP) byte_cnt <= byte_cnt + BYTE_W'(1);
      end
    end
  end

  // NOTE: the word register is pure datapath that is always loaded on accept before use, so it has no reset.
  always_ff @(posedge clk) begin
    if (accept && !rst) shreg <= load_word;
    else if (state == STOP && baud_tick) shreg <= shreg >> 8;
  end

endmodule

// File: tb/tb_uart_fp_tx.sv
// Self-checking bench for uart_fp_tx: per-cycle line model for a small instance, UART receiver for large ones.
// Honours UART_TX_CHECKSUM_EN by expecting the extra XOR frame when it is defined.

module tb_uart_fp_tx;

  localparam int S_DIV = 16;
  localparam int S_N   = 2;
  localparam int D_DIV = 217;
  localparam int D_N   = 8;
  localparam int W_DIV = 8;
  localparam int W_N   = 48;
`ifdef UART_TX_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0, s_ready, s_txd, s_busy;
  logic [15:0]   s_data  = '0;
  logic          d_valid = 1'b0, d_ready, d_txd, d_busy;
  logic [63:0]   d_data  = '0;
  logic          w_valid = 1'b0, w_ready, w_txd, w_busy;
  logic [383:0]  w_data  = '0;

  uart_fp_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .N_BYTES(S_N)) dut_s (
    .clk(clk), .rst(rst), .i_valid(s_valid), .i_data(s_data),
    .o_ready(s_ready), .o_txd(s_txd), .o_busy(s_busy));

  uart_fp_tx #(.N_BYTES(D_N)) dut_d (
    .clk(clk), .rst(rst), .i_valid(d_valid), .i_data(d_data),
    .o_ready(d_ready), .o_txd(d_txd), .o_busy(d_busy));

  uart_fp_tx #(.CLK_FREQ(W_DIV * 460800), .N_BYTES(W_N)) dut_w (
    .clk(clk), .rst(rst), .i_valid(w_valid), .i_data(w_data),
    .o_ready(w_ready), .o_txd(w_txd), .o_busy(w_busy));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frames to send for a word: its n bytes low first, plus the XOR byte when the checksum is enabled.
  function automatic byte_q_t frames_of(input logic [383:0] w, input int n);
    byte_q_t q;
    logic [7:0] x = '0;
    for (int i = 0; i < n; i++) begin
      q.push_back(8'(w >> (8 * i)));
      x ^= 8'(w >> (8 * i));
    end
    if (CS) q.push_back(x);
    return q;
  endfunction

  // Expected line level k cycles after the accept edge: 10 slots of div cycles per frame.
  function automatic logic line_at(input byte_q_t fr, input int div, input int k);
    int f = (k - 1) / (10 * div);
    int p = ((k - 1) % (10 * div)) / div;
    logic [7:0] by;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    by = fr[f];
    return by[0] ? ((by >> (p - 1)) & 8'h01) != 0 : ((by >> (p - 1)) & 8'h01) != 0;
  endfunction

  function automatic logic txd_of(input int sel);
    return (sel == 1) ? d_txd : w_txd;
  endfunction

  function automatic logic ready_of(input int sel);
    return (sel == 1) ? d_ready : w_ready;
  endfunction

  task automatic offer_s(input logic [15:0] w);
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_wait", 384'(s_ready), 384'(1));
    s_valid = 1'b1;
    s_data  = w;
    @(posedge clk);
  endtask

  // Checks every cycle of one word on the small instance; with keep set, i_valid stays high and
  // i_data churns, and the value present when o_ready returns is handed back as the next word.
  task automatic xmit_s(input logic [15:0] w, input bit keep, output logic [15:0] nxt);
    byte_q_t fr = frames_of(384'(w), S_N);
    int t = 10 * S_DIV * fr.size();
    int e0;
    nxt = '0;
    for (int k = 1; k <= t + 1; k++) begin
      @(negedge clk);
      e0 = errors;
      if (keep) s_data = 16'($urandom);
      else s_valid = 1'b0;
      if (k <= t) begin
        check("s_txd", 384'(s_txd), 384'(line_at(fr, S_DIV, k)));
        check("s_ready_busy", 384'({s_ready, s_busy}), 384'(2'b01));
      end else begin
        check("s_txd_end", 384'(s_txd), 384'(1));
        check("s_ready_busy_end", 384'({s_ready, s_busy}), 384'(2'b10));
        nxt = s_data;
      end
      if (errors != e0) break;
    end
  endtask

  task automatic offer_big(input int sel, input logic [383:0] w);
    int n = 0;
    @(negedge clk);
    while (!ready_of(sel) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("big_ready_wait", 384'(ready_of(sel)), 384'(1));
    if (sel == 1) begin
      d_valid = 1'b1;
      d_data  = w[63:0];
    end else begin
      w_valid = 1'b1;
      w_data  = w;
    end
    @(posedge clk);
  endtask

  // Mid-bit sampling receiver: hunts each start edge, reassembles the word, times o_ready.
  task automatic rx_big(input int sel, input int div, input int n, input logic [383:0] w);
    byte_q_t fr = frames_of(w, n);
    logic [383:0] got = '0;
    logic [7:0] b = '0;
    int k = 0;
    int lim = 10 * div * fr.size() + 20;
    for (int f = 0; f < fr.size(); f++) begin
      do begin
        @(negedge clk);
        k++;
        if (k == 1) begin
          d_valid = 1'b0;
          w_valid = 1'b0;
        end
      end while (txd_of(sel) !== 1'b0 && k < lim);
      check("rx_start_cycle", 384'(k), 384'(f * 10 * div + 1));
      if (k >= lim) break;
      repeat (div / 2) begin @(negedge clk); k++; end
      check("rx_start_mid", 384'(txd_of(sel)), 384'(0));
      for (int j = 0; j < 8; j++) begin
        repeat (div) begin @(negedge clk); k++; end
        b = {txd_of(sel), b[7:1]};
      end
      repeat (div) begin @(negedge clk); k++; end
      check("rx_stop", 384'(txd_of(sel)), 384'(1));
      check("rx_frame", 384'(b), 384'(fr[f]));
      if (f < n) got = got | (384'(b) << (8 * f));
    end
    while (ready_of(sel) !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("rx_ready_latency", 384'(k), 384'(10 * div * fr.size() + 1));
    check("rx_word", got, w);
  endtask

  initial begin
    logic [15:0]  nx, nx2, sw;
    logic [383:0] big;
    int e0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_vals", 384'({s_txd, s_ready, s_busy, d_txd, d_ready, d_busy, w_txd, w_ready, w_busy}),
          384'(9'b100_100_100));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 384'({s_ready, d_ready, w_ready}), 384'(3'b111));

    // Idle line: no words offered for 10000 cycles.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      e0 = errors;
      check("idle_line", 384'({s_txd, s_busy, d_txd, d_busy, w_txd, w_busy}), 384'(6'b10_10_10));
      if (errors != e0) break;
    end

    // Framing of 16'hA55A, then a few random words.
    offer_s(16'hA55A);
    xmit_s(16'hA55A, 1'b0, nx);
    repeat (3) begin
      sw = 16'($urandom);
      offer_s(sw);
      xmit_s(sw, 1'b0, nx);
    end

    // Handshake: i_valid held high with churning data; the value at o_ready is the next word.
    sw = 16'($urandom);
    offer_s(sw);
    xmit_s(sw, 1'b1, nx);
    xmit_s(nx, 1'b0, nx2);

    // Reset during bit 4 of byte 0; the handshake is offered during reset and must be ignored.
    sw = 16'($urandom);
    offer_s(sw);
    for (int k = 1; k <= 5 * S_DIV + 8; k++) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    check("s_bit4_level", 384'(s_txd), 384'(sw[4]));
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("s_in_reset", 384'({s_txd, s_ready, s_busy}), 384'(3'b100));
    end
    s_valid = 1'b0;
    rst     = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("s_after_reset", 384'({s_txd, s_ready, s_busy}), 384'(3'b110));
    end
    offer_s(16'h00FF);
    xmit_s(16'h00FF, 1'b0, nx);

    // Default clock/baud (DIV=217) instance, 8-byte word.
    big = '0;
    for (int i = 0; i < 2; i++) big = big | (384'($urandom) << (32 * i));
    offer_big(1, big);
    rx_big(1, D_DIV, D_N, big);

    // Full 384-bit Fp word, 48 frames.
    big = '0;
    for (int i = 0; i < 12; i++) big = big | (384'($urandom) << (32 * i));
    offer_big(2, big);
    rx_big(2, W_DIV, W_N, big);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
